// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single write port of the 32x64 register file between two
// producers. Port 0 is the pipeline writeback and port 1 is the
// network-interface / memory load return. Each port feeds a small FIFO. A
// round-robin arbiter drains at most one write per cycle into a registered
// write stage, and that stage drives the regfile write port. A combinational
// hazard query tells decode whether a register still has a write in flight.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   p0_valid/ready/addr/sel/data  port 0 write request (valid/ready handshake)
//   p1_valid/ready/addr/sel/data  port 1 write request (valid/ready handshake)
//   rf_we/rf_addr_wr/rf_sel/rf_data_in  registered regfile write port
//   chk_addr                    hazard query address
//   hazard                      write to chk_addr pending in a FIFO or the
//                               write stage
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [2:0]            p0_sel,
  input  logic [0:DATA_WIDTH-1] p0_data,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [2:0]            p1_sel,
  input  logic [0:DATA_WIDTH-1] p1_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr_wr,
  output logic [2:0]            rf_sel,
  output logic [0:DATA_WIDTH-1] rf_data_in,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  output logic                  hazard
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0]      PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  // The two producer ports folded into arrays so both FIFOs share one description.
  logic                  in_valid_s [2];
  logic [ADDR_WIDTH-1:0] in_addr_s  [2];
  logic [2:0]            in_sel_s   [2];
  logic [0:DATA_WIDTH-1] in_data_s  [2];

  // FIFO storage and bookkeeping, one set per port.
  logic [ADDR_WIDTH-1:0] q_addr_r [2][FIFO_DEPTH];
  logic [2:0]            q_sel_r  [2][FIFO_DEPTH];
  logic [0:DATA_WIDTH-1] q_data_r [2][FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_vld_r  [2];
  logic [PTR_W-1:0]      wr_ptr_r [2];
  logic [PTR_W-1:0]      rd_ptr_r [2];
  logic [CNT_W-1:0]      count_r  [2];

  // Port that won the most recent grant (1 after reset so port 0 goes first).
  logic                  last_port_r;

  logic [1:0]            ready_s;
  logic [1:0]            nonempty_s;
  logic [1:0]            store_s;
  logic [1:0]            grant_s;
  logic                  grant_any_s;
  logic                  grant_port_s;
  logic                  hit_s;

  assign in_valid_s[0] = p0_valid;
  assign in_valid_s[1] = p1_valid;
  assign in_addr_s[0]  = p0_addr;
  assign in_addr_s[1]  = p1_addr;
  assign in_sel_s[0]   = p0_sel;
  assign in_sel_s[1]   = p1_sel;
  assign in_data_s[0]  = p0_data;
  assign in_data_s[1]  = p1_data;

  assign p0_ready = ready_s[0];
  assign p1_ready = ready_s[1];

  // Per-port ready/occupancy flags and store qualification.
  // Ready looks only at registered occupancy, so a pop in the same cycle does
  // not open a slot early. Address 0 completes the handshake but is dropped.
  always_comb begin
    ready_s    = 2'b00;
    nonempty_s = 2'b00;
    store_s    = 2'b00;
    for (int p = 0; p < 2; p++) begin
      ready_s[p]    = (count_r[p] < DEPTH_CNT);
      nonempty_s[p] = (count_r[p] != CNT_ZERO);
      store_s[p]    = in_valid_s[p] && ready_s[p] && (in_addr_s[p] != ADDR_ZERO);
    end
  end

  // Round-robin arbitration: a lone requester wins; on contention the port
  // that did not win last time is granted.
  always_comb begin
    grant_s = 2'b00;
    case (nonempty_s)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_port_r ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
    grant_any_s  = |grant_s;
    grant_port_s = grant_s[1];
  end

  // FIFO pointers, occupancy, entry-valid flags and the round-robin pointer.
  // A store never lands on the head slot while it is occupied, so the set and
  // clear of q_vld_r in the same cycle always touch different bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr_r[p] <= PTR_ZERO;
        rd_ptr_r[p] <= PTR_ZERO;
        count_r[p]  <= CNT_ZERO;
        q_vld_r[p]  <= {FIFO_DEPTH{1'b0}};
      end
      last_port_r <= 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (store_s[p]) begin
          wr_ptr_r[p]              <= wr_ptr_r[p] + PTR_ONE;
          q_vld_r[p][wr_ptr_r[p]]  <= 1'b1;
        end
        if (grant_s[p]) begin
          rd_ptr_r[p]              <= rd_ptr_r[p] + PTR_ONE;
          q_vld_r[p][rd_ptr_r[p]]  <= 1'b0;
        end
        case ({store_s[p], grant_s[p]})
          2'b10:   count_r[p] <= count_r[p] + CNT_ONE;
          2'b01:   count_r[p] <= count_r[p] - CNT_ONE;
          default: count_r[p] <= count_r[p];
        endcase
      end
      if (grant_any_s) begin
        last_port_r <= grant_port_s;
      end
    end
  end

  // FIFO payload storage; contents are qualified by q_vld_r, so no reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (store_s[p]) begin
        q_addr_r[p][wr_ptr_r[p]] <= in_addr_s[p];
        q_sel_r[p][wr_ptr_r[p]]  <= in_sel_s[p];
        q_data_r[p][wr_ptr_r[p]] <= in_data_s[p];
      end
    end
  end

  // Registered write stage; rf_we pulses for one cycle per grant while the
  // address/sel/data hold their last values between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_addr_wr <= ADDR_ZERO;
      rf_sel     <= 3'b000;
      rf_data_in <= DATA_ZERO;
    end else if (grant_any_s) begin
      rf_we      <= 1'b1;
      rf_addr_wr <= q_addr_r[grant_port_s][rd_ptr_r[grant_port_s]];
      rf_sel     <= q_sel_r[grant_port_s][rd_ptr_r[grant_port_s]];
      rf_data_in <= q_data_r[grant_port_s][rd_ptr_r[grant_port_s]];
    end else begin
      rf_we      <= 1'b0;
    end
  end

  // Hazard search over every valid FIFO entry of both ports.
  always_comb begin
    hit_s = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        hit_s = hit_s | (q_vld_r[p][i] & (q_addr_r[p][i] == chk_addr));
      end
    end
  end

  // Register 0 never carries a real write, so it never reports a hazard.
  assign hazard = (chk_addr != ADDR_ZERO) &&
                  (hit_s || (rf_we && (rf_addr_wr == chk_addr)));

endmodule
